// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//
// Purpose:
//   Debounces WIDTH independent mechanical push-buttons. Each raw pin first
//   passes through a two-flop synchronizer. Its polarity is then normalised
//   so that 1 always means "pressed". A change is accepted only after the
//   normalised value has differed from the current debounced level for
//   DEBOUNCE_CYCLES consecutive clocks. Every accepted change produces a
//   one-cycle press or release pulse.
//
// Parameters:
//   WIDTH           - number of independent buttons
//   DEBOUNCE_CYCLES - consecutive differing cycles required to accept a change
//                     (legal range 2 .. 2^24)
//   ACTIVE_LOW      - 1 when the raw pin reads low while the button is pressed
//
// Ports:
//   clk         - single clock, all logic on its rising edge
//   reset       - synchronous, active-high reset
//   btn_raw     - asynchronous raw button pins
//   btn_level   - debounced level per button, 1 = pressed
//   btn_press   - one-cycle pulse when a press is accepted
//   btn_release - one-cycle pulse when a release is accepted
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release
);

  // The counter only has to reach DEBOUNCE_CYCLES-1. That value always fits
  // in clog2(DEBOUNCE_CYCLES) bits, even when DEBOUNCE_CYCLES is a power of two.
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0]  IDLE_PIN = {WIDTH{ACTIVE_LOW}};

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_release;
  logic [CNT_W-1:0] r_count [WIDTH];

  logic [WIDTH-1:0] w_norm;
  logic [WIDTH-1:0] w_differs;
  logic [WIDTH-1:0] w_accept;

  // Polarity is fixed after the synchronizer, so norm = 1 always means pressed.
  // A bit is accepted on the edge where it still differs from the level and
  // its counter has already reached the last qualifying value.
  always_comb begin
    w_norm    = r_sync2 ^ IDLE_PIN;
    w_differs = w_norm ^ r_level;
    w_accept  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_differs[i] && (r_count[i] == CNT_LAST);
    end
  end

  // Synchronizer, per-bit qualification counters, debounced level and pulses.
  // Reset loads the idle pin value into the synchronizer. A button that is
  // already held at reset is therefore seen as a fresh change and produces a
  // normal press. A single agreeing cycle clears the counter, so bounce
  // restarts the qualification. The counter is cleared on accept and so
  // never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= IDLE_PIN;
      r_sync2   <= IDLE_PIN;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level   <= r_level ^ w_accept;
      r_press   <= w_accept & w_norm;
      r_release <= w_accept & ~w_norm;
      for (int i = 0; i < WIDTH; i++) begin
        if (!w_differs[i] || w_accept[i]) begin
          r_count[i] <= '0;
        end else begin
          r_count[i] <= r_count[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign btn_release = r_release;

endmodule

// File: tb/tb_button_debouncer.sv
// ---------------------------------------------------------------------------
// tb_button_debouncer
//
// Purpose:
//   Self-checking bench for button_debouncer with WIDTH=4, DEBOUNCE_CYCLES=4
//   and ACTIVE_LOW=1. It runs a sequence of directed scenarios (idle hold,
//   press, bounce, release, all-bits press, reset mid-qualification) and then
//   a randomized phase. Outputs are compared against a behavioural model and,
//   in the directed steps, also against fixed expected latencies.
// ---------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam bit AL = 1'b1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] btn_raw = '1;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_press;
  logic [W-1:0] btn_release;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Behavioural model. The pin value that matters at an edge is the one
  // sampled two edges earlier, because it has to travel through two
  // sampling stages. Reset makes both stages look idle. A change is accepted
  // once D consecutive edges have seen a pressed value that differs from
  // the current level. The edge at which the differing run began is kept,
  // and the change is accepted when the run length reaches D.
  logic [W-1:0] rawHist[$];
  logic [W-1:0] mLevel = '0;
  logic [W-1:0] mPress = '0;
  logic [W-1:0] mRelease = '0;
  logic [W-1:0] normNow;
  int           edgeNum = 0;
  int           runStart[W];

  always @(posedge clk) begin
    edgeNum++;
    if (reset) begin
      mLevel   = '0;
      mPress   = '0;
      mRelease = '0;
      rawHist.delete();
      rawHist.push_back({W{AL}});
      rawHist.push_back({W{AL}});
      for (int b = 0; b < W; b++) runStart[b] = -1;
    end else if (rawHist.size() >= 2) begin
      normNow  = rawHist[rawHist.size()-2] ^ {W{AL}};
      mPress   = '0;
      mRelease = '0;
      for (int b = 0; b < W; b++) begin
        if (normNow[b] == mLevel[b]) begin
          runStart[b] = -1;
        end else begin
          if (runStart[b] < 0) runStart[b] = edgeNum;
          if (edgeNum - runStart[b] + 1 >= D) begin
            mLevel[b] = normNow[b];
            if (normNow[b]) mPress[b] = 1'b1;
            else            mRelease[b] = 1'b1;
            runStart[b] = -1;
          end
        end
      end
      rawHist.push_back(btn_raw);
      while (rawHist.size() > 2) void'(rawHist.pop_front());
    end
  end

  // Drive pins and reset. Called just after a falling edge, so the values
  // are stable well before the next rising edge.
  task automatic applyStimulus(input logic [W-1:0] raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
  endtask

  // Compare all three outputs against the given expectations.
  task automatic checkOutput(input string tag, input logic [W-1:0] eLevel,
                             input logic [W-1:0] ePress, input logic [W-1:0] eRelease);
    checks++;
    assert (btn_level === eLevel) else begin
      errors++;
      $error("[TB] FAIL %s level observed=%h expected=%h", tag, btn_level, eLevel);
    end
    checks++;
    assert (btn_press === ePress) else begin
      errors++;
      $error("[TB] FAIL %s press observed=%h expected=%h", tag, btn_press, ePress);
    end
    checks++;
    assert (btn_release === eRelease) else begin
      errors++;
      $error("[TB] FAIL %s release observed=%h expected=%h", tag, btn_release, eRelease);
    end
    checks++;
    assert ((btn_press & btn_release) === '0) else begin
      errors++;
      $error("[TB] FAIL %s overlap observed=%h expected=0", tag, btn_press & btn_release);
    end
  endtask

  // Advance one cycle and compare against the model, sampling on the
  // falling edge.
  task automatic stepModel(input string tag);
    @(negedge clk);
    checkOutput(tag, mLevel, mPress, mRelease);
  endtask

  // Compare a single bit against a fixed expectation.
  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  initial begin
    logic [W-1:0] raw;
    int           holdLeft[W];

    // Reset state.
    applyStimulus(4'hF, 1'b1);
    stepModel("reset0");
    stepModel("reset1");
    checkOutput("resetConst", 4'h0, 4'h0, 4'h0);
    applyStimulus(4'hF, 1'b0);

    // Idle pins held high: nothing is ever pressed.
    for (int k = 0; k < 20; k++) begin
      stepModel("idleHold");
      checkOutput("idleConst", 4'h0, 4'h0, 4'h0);
    end

    // Press bit 0: the level rises at edge 6 with a single press pulse.
    applyStimulus(4'hE, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      stepModel("press0");
      checkBit("press0Level", btn_level[0], k >= 6);
      checkBit("press0Pulse", btn_press[0], k == 6);
    end

    // Bounce bit 1: 3 low, 1 high, repeated 5 times. It never qualifies.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus((c < 3) ? 4'hC : 4'hE, 1'b0);
        stepModel("bounce1");
        checkBit("bounce1Level", btn_level[1], 1'b0);
        checkBit("bounce1Press", btn_press[1], 1'b0);
      end
    end
    applyStimulus(4'hE, 1'b0);
    for (int k = 0; k < 6; k++) stepModel("bounceSettle");

    // Release bit 0: the level falls at edge 6 with a single release pulse.
    applyStimulus(4'hF, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      stepModel("release0");
      checkBit("release0Level", btn_level[0], k < 6);
      checkBit("release0Pulse", btn_release[0], k == 6);
    end

    // All bits pressed together produce simultaneous level and press.
    applyStimulus(4'h0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      stepModel("pressAll");
      if (k == 6) checkOutput("pressAllEdge6", 4'hF, 4'hF, 4'h0);
      if (k == 5) checkOutput("pressAllEdge5", 4'h0, 4'h0, 4'h0);
    end
    applyStimulus(4'hF, 1'b0);
    for (int k = 0; k < 10; k++) stepModel("releaseAll");

    // Reset while bit 2's counter sits at 2, then requalify from scratch.
    applyStimulus(4'hB, 1'b0);
    for (int k = 1; k <= 4; k++) stepModel("preReset");
    applyStimulus(4'hB, 1'b1);
    stepModel("midReset");
    checkOutput("midResetConst", 4'h0, 4'h0, 4'h0);
    applyStimulus(4'hB, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      stepModel("afterReset");
      checkBit("afterResetLevel", btn_level[2], k >= 6);
      checkBit("afterResetPulse", btn_press[2], k == 6);
    end

    // Randomized phase: per-bit hold lengths around D with occasional resets.
    raw = btn_raw;
    for (int b = 0; b < W; b++) holdLeft[b] = 1;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < W; b++) begin
        holdLeft[b]--;
        if (holdLeft[b] <= 0) begin
          raw[b]      = $urandom_range(0, 1);
          holdLeft[b] = $urandom_range(1, 9);
        end
      end
      applyStimulus(raw, ($urandom_range(0, 99) == 0));
      stepModel("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
